// File: rtl/ft_fifo_arbiter.sv
// ft_fifo_arbiter: FT2232H 245-sync FIFO bus scheduler sharing the half-duplex bus between RX and TX paths.
// Optional statistics counters (stats_clr, rx_words, tx_words) exist only when FT_ARB_STATS_EN is defined.
module ft_fifo_arbiter #(
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rxf_n,
  input  logic              txe_n,
  input  logic              fa_full,
  input  logic              fb_empty,
`ifdef FT_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] rx_words,
  output logic [STAT_W-1:0] tx_words,
`endif
  output logic              oe_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              data_oe,
  output logic              fa_wr,
  output logic              fb_rd,
  output logic              busy,
  output logic              dir_tx
);

  typedef enum logic [2:0] {S_IDLE, S_RX_OE, S_RX, S_TX_PRE, S_TX, S_TURN} state_t;

  localparam logic [16:0] MAX_B     = 17'(MAX_BURST);
  localparam logic [3:0]  TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic [3:0]  turn_q, turn_d;
  logic        oe_n_q, oe_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic        data_oe_q, data_oe_d, fa_wr_q, fa_wr_d, fb_rd_q, fb_rd_d;
  logic        busy_q, busy_d, dir_tx_q, dir_tx_d;
  logic        rx_req, tx_req, grant_tx, rx_xfer, tx_xfer;

  assign rx_req   = !rxf_n && !fa_full;
  assign tx_req   = !txe_n && !fb_empty;
  assign grant_tx = tx_req && (!rx_req || !dir_tx_q);
  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
  assign rx_xfer  = (state_q == S_RX) && !rxf_n && !fa_full;
  // wr_n_q low in TX is the held-word flag: TX is left the same edge the word is consumed without a refill.
  assign tx_xfer  = (state_q == S_TX) && !wr_n_q && !txe_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    turn_d    = turn_q;
    dir_tx_d  = dir_tx_q;
    oe_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    data_oe_d = 1'b0;
    fa_wr_d   = rx_xfer;
    fb_rd_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && (rx_req || tx_req)) begin
          dir_tx_d = grant_tx;
          cnt_d    = '0;
          if (grant_tx) begin
            state_d   = S_TX_PRE;
            data_oe_d = 1'b1;
            fb_rd_d   = 1'b1;
          end else begin
            state_d = S_RX_OE;
            oe_n_d  = 1'b0;
          end
        end
      end
      S_RX_OE: begin
        state_d = S_RX;
        oe_n_d  = 1'b0;
        rd_n_d  = 1'b0;
      end
      S_RX: begin
        if (rx_xfer) cnt_d = cnt_q + 16'd1;
        if (rxf_n || fa_full || (rx_xfer && (cnt_inc >= MAX_B))) begin
          state_d = S_TURN;
          turn_d  = TURN_LAST;
        end else begin
          oe_n_d = 1'b0;
          rd_n_d = 1'b0;
        end
      end
      S_TX_PRE: begin
        state_d   = S_TX;
        data_oe_d = 1'b1;
        wr_n_d    = 1'b0;
      end
      S_TX: begin
        data_oe_d = 1'b1;
        wr_n_d    = 1'b0;
        if (tx_xfer) begin
          cnt_d = cnt_q + 16'd1;
          if (!fb_empty && (cnt_inc < MAX_B)) begin
            fb_rd_d = 1'b1;
          end else begin
            state_d   = S_TURN;
            turn_d    = TURN_LAST;
            data_oe_d = 1'b0;
            wr_n_d    = 1'b1;
          end
        end
      end
      S_TURN: begin
        if (turn_q == '0) state_d = S_IDLE;
        else              turn_d  = turn_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      turn_q    <= '0;
      oe_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      fa_wr_q   <= 1'b0;
      fb_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      dir_tx_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      oe_n_q    <= oe_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      data_oe_q <= data_oe_d;
      fa_wr_q   <= fa_wr_d;
      fb_rd_q   <= fb_rd_d;
      busy_q    <= busy_d;
      dir_tx_q  <= dir_tx_d;
    end
  end

  assign oe_n    = oe_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign data_oe = data_oe_q;
  assign fa_wr   = fa_wr_q;
  assign fb_rd   = fb_rd_q;
  assign busy    = busy_q;
  assign dir_tx  = dir_tx_q;

`ifdef FT_ARB_STATS_EN
  logic [STAT_W-1:0] rx_words_q, tx_words_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_words_q <= '0;
      tx_words_q <= '0;
    end else if (stats_clr) begin
      rx_words_q <= '0;
      tx_words_q <= '0;
    end else begin
      if (rx_xfer) rx_words_q <= rx_words_q + 1'b1;
      if (tx_xfer) tx_words_q <= tx_words_q + 1'b1;
    end
  end

  assign rx_words = rx_words_q;
  assign tx_words = tx_words_q;
`endif

endmodule
